// File: rtl/circle_cmd_sched.sv
// circle_cmd_sched: queues circle draw commands in a small FIFO and feeds them
// one at a time to the circle engine over its level start/done handshake.
// Optional feature macro: CULL_OFFSCREEN_EN (drops circles that cannot touch
// the 160x120 screen and adds the cull_count output).
module circle_cmd_sched #(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [7:0]              cmd_centre_x,
  input  logic [6:0]              cmd_centre_y,
  input  logic [7:0]              cmd_radius,
  input  logic [2:0]              cmd_colour,
  input  logic                    flush,
  output logic                    eng_start,
  output logic [7:0]              eng_centre_x,
  output logic [6:0]              eng_centre_y,
  output logic [7:0]              eng_radius,
  output logic [2:0]              eng_colour,
  input  logic                    eng_done,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    busy,
  output logic [15:0]             issued_count
`ifdef CULL_OFFSCREEN_EN
  ,
  output logic [15:0]             cull_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 26;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [3:0]    GAP_LAST   = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_RELEASE,
    ST_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [EW-1:0]   fifo_mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [EW-1:0]   eng_cmd_q, eng_cmd_d;
  logic            eng_start_q, eng_start_d;
  logic [15:0]     issued_q, issued_d;
  logic [3:0]      gap_cnt_q, gap_cnt_d;

  logic            push;
  logic            pop;
  logic            launch;
  logic            culled;
  logic [EW-1:0]   cmd_word;
  logic [EW-1:0]   head_word;

  // Entry layout: {centre_x[7:0], centre_y[6:0], radius[7:0], colour[2:0]}
  assign cmd_word  = {cmd_centre_x, cmd_centre_y, cmd_radius, cmd_colour};
  assign head_word = fifo_mem[rd_ptr_q];

  // cmd_ready follows the registered count, so a push is refused when full
  // even if a pop happens in the same cycle.
  assign cmd_ready = (count_q != FULL_COUNT);
  assign push      = cmd_valid && cmd_ready && !flush;
  assign pop       = (state_q == ST_IDLE) && (count_q != '0) && !flush;
  assign launch    = pop && !culled;

`ifdef CULL_OFFSCREEN_EN
  logic [9:0]  head_x;
  logic [9:0]  head_y;
  logic [9:0]  head_r;
  logic [15:0] cull_q, cull_d;

  // Widened to 10 bits so 159+255 cannot overflow.
  assign head_x = {2'b00, head_word[25:18]};
  assign head_y = {3'b000, head_word[17:11]};
  assign head_r = {2'b00, head_word[10:3]};
  assign culled = (head_x > (10'd159 + head_r)) || (head_y > (10'd119 + head_r));

  // Culled-command counter next value
  always_comb begin
    cull_d = cull_q;
    if (pop && culled) cull_d = cull_q + 16'd1;
  end

  // Culled-command counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cull_q <= '0;
    else        cull_q <= cull_d;
  end

  assign cull_count = cull_q;
`else
  assign culled = 1'b0;
`endif

  // FIFO pointer/count next values; flush drops everything queued
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO storage write; contents need no reset since the count gates reads
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= cmd_word;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (launch) state_d = ST_LOAD;
      ST_LOAD:    state_d = ST_RUN;
      ST_RUN:     if (eng_done) state_d = ST_RELEASE;
      ST_RELEASE: if (!eng_done) state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:     if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: engine start, captured command, completion and gap counters
  always_comb begin
    eng_cmd_d   = eng_cmd_q;
    eng_start_d = 1'b0;
    issued_d    = issued_q;
    gap_cnt_d   = 4'd0;
    case (state_q)
      ST_IDLE: if (launch) eng_cmd_d = head_word;
      ST_LOAD: eng_start_d = 1'b1;
      ST_RUN: begin
        eng_start_d = !eng_done;
        if (eng_done) issued_d = issued_q + 16'd1;
      end
      ST_GAP:  gap_cnt_d = gap_cnt_q + 4'd1;
      default: ;
    endcase
  end

  // Datapath registers; reset drops eng_start immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      eng_cmd_q   <= '0;
      eng_start_q <= 1'b0;
      issued_q    <= '0;
      gap_cnt_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      eng_cmd_q   <= eng_cmd_d;
      eng_start_q <= eng_start_d;
      issued_q    <= issued_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign eng_start    = eng_start_q;
  assign eng_centre_x = eng_cmd_q[25:18];
  assign eng_centre_y = eng_cmd_q[17:11];
  assign eng_radius   = eng_cmd_q[10:3];
  assign eng_colour   = eng_cmd_q[2:0];
  assign fifo_count   = count_q;
  assign issued_count = issued_q;
  assign busy         = (state_q != ST_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_circle_cmd_sched.sv
// Testbench for circle_cmd_sched: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the scheduler.
module tb_circle_cmd_sched;
  localparam int DEPTH = 4;
  localparam int GAP   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_centre_x = '0;
  logic [6:0]  cmd_centre_y = '0;
  logic [7:0]  cmd_radius = '0;
  logic [2:0]  cmd_colour = '0;
  logic        flush = 1'b0;
  logic        eng_start;
  logic [7:0]  eng_centre_x;
  logic [6:0]  eng_centre_y;
  logic [7:0]  eng_radius;
  logic [2:0]  eng_colour;
  logic        eng_done = 1'b0;
  logic [$clog2(DEPTH):0] fifo_count;
  logic        busy;
  logic [15:0] issued_count;
`ifdef CULL_OFFSCREEN_EN
  logic [15:0] cull_count;
`endif

  circle_cmd_sched #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_centre_x (cmd_centre_x),
    .cmd_centre_y (cmd_centre_y),
    .cmd_radius   (cmd_radius),
    .cmd_colour   (cmd_colour),
    .flush        (flush),
    .eng_start    (eng_start),
    .eng_centre_x (eng_centre_x),
    .eng_centre_y (eng_centre_y),
    .eng_radius   (eng_radius),
    .eng_colour   (eng_colour),
    .eng_done     (eng_done),
    .fifo_count   (fifo_count),
    .busy         (busy),
    .issued_count (issued_count)
`ifdef CULL_OFFSCREEN_EN
    ,
    .cull_count   (cull_count)
`endif
  );

  always #10 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Timestamps of the in-flight command: popped at edge m_pop_edge, done seen
  // at m_done_edge, scheduler idle again after edge m_idle_edge.
  logic [25:0] m_q[$];
  logic [25:0] m_cur;
  bit          m_active, m_done_seen, m_released, m_start_exp;
  int          m_edge, m_pop_edge, m_done_edge, m_idle_edge;
  int unsigned m_issued, m_cull;

  task automatic model_reset();
    m_q.delete();
    m_cur = '0;
    m_active = 0; m_done_seen = 0; m_released = 0; m_start_exp = 0;
    m_edge = 0; m_pop_edge = 0; m_done_edge = 0; m_idle_edge = 0;
    m_issued = 0; m_cull = 0;
  endtask

`ifdef CULL_OFFSCREEN_EN
  function automatic bit is_culled(input logic [25:0] w);
    int x, y, r;
    x = int'(w[25:18]); y = int'(w[17:11]); r = int'(w[10:3]);
    return (x > 159 + r) || (y > 119 + r);
  endfunction
`endif

  task automatic model_update();
    bit do_push, do_pop, was_active, culled;
    logic [25:0] head;
    m_edge++;
    was_active = m_active;
    do_push = cmd_valid && (m_q.size() != DEPTH) && !flush;
    do_pop  = !was_active && (m_q.size() != 0) && !flush;
    if (was_active) begin
      if (!m_done_seen) begin
        if (m_edge >= m_pop_edge + 2 && eng_done) begin
          m_done_seen = 1; m_done_edge = m_edge;
          m_issued = (m_issued + 1) & 32'hFFFF;
        end
      end else if (!m_released) begin
        if (m_edge > m_done_edge && !eng_done) begin
          m_released = 1; m_idle_edge = m_edge + GAP;
        end
      end
      if (m_released && m_edge >= m_idle_edge) m_active = 0;
    end
    if (flush) m_q.delete();
    else begin
      if (do_pop) begin
        head = m_q.pop_front();
`ifdef CULL_OFFSCREEN_EN
        culled = is_culled(head);
`else
        culled = 0;
`endif
        if (culled) m_cull = (m_cull + 1) & 32'hFFFF;
        else begin
          m_active = 1; m_done_seen = 0; m_released = 0;
          m_pop_edge = m_edge; m_cur = head;
        end
      end
      if (do_push) m_q.push_back({cmd_centre_x, cmd_centre_y, cmd_radius, cmd_colour});
    end
    m_start_exp = m_active && !m_done_seen && (m_edge >= m_pop_edge + 1);
  endtask

  // ---------------- engine model (stimulus) ----------------
  int eng_lat = 5, eng_hold = 0, run_cnt = 0, hold_cnt = 0;
  bit eng_stall = 0, eng_rand = 0;

  task automatic engine_update();
    if (eng_start) begin
      if (run_cnt == 0 && eng_rand) begin
        eng_lat  = int'($urandom_range(1, 8));
        eng_hold = int'($urandom_range(0, 4));
      end
      run_cnt++;
      hold_cnt = 0;
      if (!eng_stall && run_cnt >= eng_lat) eng_done = 1'b1;
    end else begin
      run_cnt = 0;
      if (eng_done) begin
        if (hold_cnt >= eng_hold) eng_done = 1'b0;
        else hold_cnt++;
      end
    end
  endtask

  // One clock: model follows the edge, inputs change just after the falling edge
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    #1;
    engine_update();
  endtask

  task automatic drive_cmd(input int x, input int y, input int r, input int c);
    cmd_valid = 1'b1;
    cmd_centre_x = 8'(x); cmd_centre_y = 7'(y); cmd_radius = 8'(r); cmd_colour = 3'(c);
  endtask

  task automatic wait_idle(input int bound, input string nm);
    int n = 0;
    while (busy && n < bound) begin tick(); n++; end
    chk(nm, busy, 0);
  endtask

  task automatic wait_start(input int bound, input string nm);
    int n = 0;
    while (!eng_start && n < bound) begin tick(); n++; end
    chk(nm, eng_start, 1);
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", cmd_ready, m_q.size() != DEPTH);
      chk("fifo_count", fifo_count, m_q.size());
      chk("busy", busy, m_active || (m_q.size() != 0));
      chk("eng_start", eng_start, m_start_exp);
      chk("issued_count", issued_count, m_issued);
      if (m_start_exp) begin
        chk("eng_centre_x", eng_centre_x, m_cur[25:18]);
        chk("eng_centre_y", eng_centre_y, m_cur[17:11]);
        chk("eng_radius", eng_radius, m_cur[10:3]);
        chk("eng_colour", eng_colour, m_cur[2:0]);
      end
`ifdef CULL_OFFSCREEN_EN
      chk("cull_count", cull_count, m_cull);
`endif
    end
  end

  initial begin
    int k, n;
    bit rdy;
    // Reset state
    repeat (3) tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_issued", issued_count, 0);
    chk("rst_eng_x", eng_centre_x, 0);
    rst_n = 1'b1;
    model_reset();
    chk_en = 1'b1;
    tick();

    // 1: single command, start two edges after the push
    eng_lat = 50; eng_hold = 0;
    drive_cmd(80, 60, 30, 3);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("t1_start_n1", eng_start, 0);
    tick();
    chk("t1_start_n2", eng_start, 1);
    chk("t1_x", eng_centre_x, 80);
    chk("t1_y", eng_centre_y, 60);
    chk("t1_r", eng_radius, 30);
    chk("t1_c", eng_colour, 3);
    wait_idle(200, "t1_idle");
    chk("t1_issued", issued_count, 1);
    chk("t1_model_issued", m_issued, 1);
    $display("t1 single command: issued_count=%0d", issued_count);

    // 2: five back-to-back pushes with the engine stalled
    eng_stall = 1; eng_lat = 3;
    k = 0;
    for (int i = 0; i < 40 && k < 5; i++) begin
      drive_cmd(10 + k, 20 + k, 5 + k, k);
      rdy = cmd_ready;
      tick();
      if (rdy) k++;
    end
    cmd_valid = 1'b0;
    chk("t2_pushed", k, 5);
    chk("t2_full_count", fifo_count, 4);
    chk("t2_full_ready", cmd_ready, 0);
    tick(); tick();
    eng_stall = 0;
    wait_idle(600, "t2_idle");
    chk("t2_issued", issued_count, 6);
    $display("t2 fill and drain: issued_count=%0d", issued_count);

    // 3: done held after start drops; next start waits for done low + gap
    eng_lat = 4; eng_hold = 10;
    drive_cmd(100, 50, 10, 1); tick();
    drive_cmd(101, 51, 11, 2); tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!eng_done && n < 100) begin tick(); n++; end
    chk("t3_done_rise", eng_done, 1);
    n = 0;
    while (eng_done && n < 100) begin tick(); n++; end
    chk("t3_done_fall", eng_done, 0);
    n = 0;
    while (!eng_start && n < 100) begin tick(); n++; end
    chk("t3_gap_cycles", n, GAP + 3);
    wait_idle(300, "t3_idle");
    eng_hold = 0;
    chk("t3_issued", issued_count, 8);
    $display("t3 held done: restart after %0d cycles", n);

    // 4: flush during the first command's run
    eng_lat = 20;
    drive_cmd(30, 30, 5, 4); tick();
    drive_cmd(31, 31, 6, 5); tick();
    drive_cmd(32, 32, 7, 6); tick();
    cmd_valid = 1'b0;
    wait_start(20, "t4_start");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_flushed_count", fifo_count, 0);
    wait_idle(200, "t4_idle");
    chk("t4_issued", issued_count, 9);
    $display("t4 flush: issued_count=%0d", issued_count);

`ifdef CULL_OFFSCREEN_EN
    // 6: off-screen command culled, on-screen one issued
    eng_lat = 5;
    drive_cmd(250, 10, 20, 1); tick();
    drive_cmd(200, 60, 50, 2); tick();
    cmd_valid = 1'b0;
    wait_start(20, "t6_start");
    chk("t6_x", eng_centre_x, 200);
    chk("t6_cull_count", cull_count, 1);
    wait_idle(200, "t6_idle");
    chk("t6_issued", issued_count, 10);
    $display("t6 cull: cull_count=%0d issued_count=%0d", cull_count, issued_count);
`endif

    // Randomized traffic with random engine latency, hold and flushes
    eng_rand = 1;
    for (int i = 0; i < 1500; i++) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_centre_x = 8'($urandom_range(0, 255));
      cmd_centre_y = 7'($urandom_range(0, 127));
      cmd_radius = 8'($urandom_range(0, 255));
      cmd_colour = 3'($urandom_range(0, 7));
      flush = ($urandom_range(0, 80) == 0);
      tick();
    end
    cmd_valid = 1'b0; flush = 1'b0;
    wait_idle(3000, "rand_idle");
    eng_rand = 0; eng_hold = 0;
    $display("random phase: issued_count=%0d", issued_count);

    // 5: asynchronous reset mid-draw with two queued
    eng_stall = 1;
    drive_cmd(40, 40, 8, 1); tick();
    drive_cmd(41, 41, 9, 2); tick();
    drive_cmd(42, 42, 10, 3); tick();
    cmd_valid = 1'b0;
    wait_start(20, "t5_start");
    chk("t5_queued", fifo_count, 2);
    chk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_start", eng_start, 0);
    chk("t5_rst_count", fifo_count, 0);
    chk("t5_rst_ready", cmd_ready, 1);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_issued", issued_count, 0);
    $display("t5 async reset: eng_start=%0d fifo_count=%0d", eng_start, fifo_count);
    #40;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/circle_cmd_sched.md
Name: circle_cmd_sched

Overview:
- Command scheduler in front of the circle drawing engine.
- Buffers circle draw commands (centre, radius, colour) in a small FIFO.
- Issues them one at a time to the engine using its level start/done handshake.
- Lets a producer, such as a CPU, test sequencer or UI block, queue several circles without watching the engine's done.

Parameters:
DEPTH, 4, command FIFO entries; power of two, 2..16
GAP_CYCLES, 2, idle cycles between engine start deassertion and the next start assertion; 0..15

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  producer has a command
cmd_ready  out  1  FIFO can accept; transfer when cmd_valid && cmd_ready
cmd_centre_x  in  8  circle centre x
cmd_centre_y  in  7  circle centre y
cmd_radius  in  8  circle radius
cmd_colour  in  3  circle colour
flush  in  1  discard all queued, not-yet-issued commands
eng_start  out  1  engine start, level
eng_centre_x  out  8  held stable while eng_start=1
eng_centre_y  out  7  held stable while eng_start=1
eng_radius  out  8  held stable while eng_start=1
eng_colour  out  3  held stable while eng_start=1
eng_done  in  1  engine done, level; high until start drops
fifo_count  out  $clog2(DEPTH)+1  queued commands
busy  out  1  command in flight or queued
issued_count  out  16  commands completed by engine, wraps at 2^16

Behaviour:
Reset:
- Clock is clk; reset is rst_n, asynchronous, active-low.
- Reset forces all outputs to 0, except cmd_ready=1.
- Reset empties the FIFO and puts the FSM in IDLE.
- Reset mid-draw drops eng_start immediately; the in-flight command is lost.

FIFO:
- Write pointer, read pointer and count are registered.
- cmd_ready = (fifo_count != DEPTH).
- Push and pop in the same cycle when full: the push is refused, because cmd_ready reflects the registered count.
- Push and pop in the same cycle when not full: count unchanged.
- Pointers wrap modulo DEPTH.

FSM states IDLE, LOAD, RUN, RELEASE, GAP:
- IDLE: if fifo_count>0 and not flush, pop the head into the eng_* registers and go to LOAD.
- LOAD: assert eng_start next cycle, go to RUN.
  - A command pushed into an empty FIFO while in IDLE at cycle N pops at N+1 and gives eng_start=1 at N+2.
- RUN: eng_start=1 and eng_* held. On eng_done=1, deassert eng_start next cycle, increment issued_count, go to RELEASE.
- RELEASE: eng_start=0; wait for eng_done=0, then go to GAP.
- GAP: count GAP_CYCLES cycles, then go to IDLE. With GAP_CYCLES=0, go straight to IDLE.
- No new start is issued while eng_done=1, so back-to-back commands never see a stale done.

Flush:
- Clears the FIFO (count=0) in the cycle it is sampled.
- Does not abort a command already in LOAD/RUN/RELEASE; that command completes normally.
- A push coinciding with flush is discarded. cmd_ready stays 1 during flush.

busy = (state != IDLE) || (fifo_count != 0).

Widths:
- eng_* are registered copies of FIFO entries; no arithmetic on the coordinates.
- issued_count wraps from 0xFFFF to 0.

Optional Feature:
CULL_OFFSCREEN_EN defined:
- When popping, a command is culled if its circle cannot touch the 160x120 screen: (9-bit) centre_x > 159 + radius, or (8-bit-extended) centre_y > 119 + radius.
- A culled command is discarded in IDLE with no LOAD/RUN and no eng_start pulse. The FSM pops the next command the following cycle.
- 16-bit output cull_count (port present only with the macro) increments per culled command; it is not added to issued_count.
- Reset value of cull_count is 0.

CULL_OFFSCREEN_EN undefined:
- All commands are issued to the engine unchanged and no cull_count port exists.

Test Plan:
1. Single command (80,60,r=30,colour=3) into an empty FIFO at cycle N -> eng_start rises at N+2 with those values; engine model raises done after 50 cycles -> eng_start falls the next cycle; issued_count=1; busy=0 after done falls plus GAP_CYCLES.
2. Push 5 commands back-to-back, DEPTH=4, engine stalled -> first pops, next 4 fill the FIFO, cmd_ready=0 at count=4; each later completion frees one slot; engine sees all 5 in order; issued_count=5.
3. Engine model holds done high 10 cycles after start drops -> scheduler stays in RELEASE; next eng_start only after done low plus GAP_CYCLES=2.
4. Queue 3 commands, assert flush during the first command's RUN -> first completes, the other two never issued; fifo_count=0; issued_count=1.
5. Assert rst_n=0 while eng_start=1 with 2 queued -> eng_start=0, fifo_count=0, cmd_ready=1 immediately (asynchronous, before the next clk edge).
6. CULL_OFFSCREEN_EN: push (250,10,r=20) then (200,60,r=50) -> first culled (250 > 179), cull_count=1, no start; second issued (200 <= 209).
